decode_regfile: RTL and testbench
=================================

Name: decode_regfile

Overview:
- Write-side counterpart of the writeback stage: consumes RegWrite_ID / RD_ID / MemtoRegOut_ID and commits results into the architectural register file.
- Provides two read ports for the ID stage, with same-cycle write-to-read bypass.
- Registers both operands into an ID/EX operand latch with stall and flush control.
- Sits between instruction decode and the execute stage.

Parameters:
- NREG, 32, number of architectural registers.
- XLEN, 64, register width in bits.
- ZERO_REG, 31, index of the hardwired-zero register (XZR): reads 0, writes ignored.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- RegWrite_ID  input  1  write enable from writeback
- RD_ID  input  5  write address from writeback
- MemtoRegOut_ID  input  XLEN  write data from writeback
- RN_ID  input  5  read address, port 1
- RM_ID  input  5  read address, port 2
- Valid_ID  input  1  ID holds a real instruction
- Stall_ID  input  1  hold the ID/EX latch
- Flush_ID  input  1  squash the ID/EX latch
- ReadData1_EX  output  XLEN  latched operand 1
- ReadData2_EX  output  XLEN  latched operand 2
- Valid_EX  output  1  latched operand valid
- Bypass1_EX, Bypass2_EX  output  1 each  operand was bypassed (debug/coverage)

Behaviour:
- Reset:
  - Asynchronous and active-high; takes effect immediately, independent of clk.
  - All NREG registers, ReadData1_EX, ReadData2_EX, Valid_EX and both Bypass outputs go to 0.
  - Reset asserted mid-operation discards any write in flight; the first write is accepted on the first rising edge with reset low.
- Write:
  - On a rising edge, if RegWrite_ID=1 and RD_ID!=ZERO_REG, then reg[RD_ID] <= MemtoRegOut_ID.
  - A write to ZERO_REG is a no-op.
  - Write enable is not qualified by Stall_ID or Flush_ID: writeback always commits.
- Read (combinational, inside the block):
  - For each port p with address A: if A==ZERO_REG, the value is 0.
  - Otherwise, if RegWrite_ID=1 and RD_ID==A, the value is MemtoRegOut_ID (bypass) and bypass_p=1.
  - Otherwise the value is reg[A].
  - Both ports may bypass in the same cycle, from the same source.
- ID/EX latch, evaluated on the rising edge, in priority order:
  1. Flush_ID=1: Valid_EX<=0, operands<=0, Bypass<=0. Flush wins over stall.
  2. Stall_ID=1: all EX outputs hold.
  3. Otherwise: ReadDataN_EX <= port value, BypassN_EX <= bypass_N, Valid_EX <= Valid_ID.
- Latency: address presented in cycle N → operand visible at EX outputs after edge N+1 (one cycle).
- During a stall, a write to the held source register does NOT update the latched operand. Re-read is the hazard unit's job: it must flush, or release the stall and let ID re-present the address.
- Index width: addresses are 5 bits; with NREG=32 every address is valid. For NREG<32, reads of out-of-range addresses return 0 and writes to them are ignored.

Decomposition:
- Shared package (pipeline_pkg):
  - XLEN, NREG, ZERO_REG, REG_ADDR_W=5.
  - Typedef for the ID/EX operand bundle {valid, rd1, rd2, byp1, byp2}.
- One sub-module: regfile_core.
  - Contains the storage array, the write port, and two combinational read ports with bypass and zero logic.
  - decode_regfile wraps it with the ID/EX latch and the stall/flush logic.

Test Plan:
- Reset, no writes, RN=3, RM=31, Valid_ID=1 → after 1 edge: ReadData1_EX=0, ReadData2_EX=0, Valid_EX=1, Bypass=0.
- Write X5=0x0000_0000_DEAD_BEEF in cycle N; read RN=5 in cycle N+1 → EX operand 0xDEADBEEF, Bypass1_EX=0.
- Same-cycle bypass: RegWrite=1, RD=7, data=0x1234, RN=RM=7 → ReadData1_EX=ReadData2_EX=0x1234, both Bypass=1; X7 also holds 0x1234 afterwards.
- Write RD=31 with data 0xFFFF…FF, then read RN=31 → 0. Also read RN=31 in the same write cycle → 0 and Bypass1_EX=0.
- Stall/flush:
  - Latch X2=0xAA, then raise Stall_ID for 3 cycles while writing X2=0xBB → EX holds 0xAA.
  - Assert Stall_ID and Flush_ID together → Valid_EX=0 and operands=0 on the next edge.
- Async reset mid-stream: with X9=0x55 and Valid_EX=1, pulse reset between edges → outputs 0 immediately, without waiting for an edge. A subsequent read of X9 returns 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared decode/execute constants and the ID/EX operand bundle.
package pipeline_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned NREG       = 32;
  localparam int unsigned ZERO_REG   = 31;
  localparam int unsigned REG_ADDR_W = 5;

  // Operand bundle carried from ID into EX.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            byp1;
    logic            byp2;
  } idex_t;

  // True when a 5-bit register address names a storage slot that exists.
  function automatic logic addr_in_range(input logic [REG_ADDR_W-1:0] a,
                                         input int unsigned nreg);
    return (32'(a) < nreg);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural register file: storage, one write port, two read ports
// with hardwired-zero register and same-cycle write-to-read bypass.
module regfile_core
  import pipeline_pkg::*;
#(
  parameter int unsigned NREG     = pipeline_pkg::NREG,
  parameter int unsigned XLEN     = pipeline_pkg::XLEN,
  parameter int unsigned ZERO_REG = pipeline_pkg::ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [REG_ADDR_W-1:0] i_rn,
  input  logic [REG_ADDR_W-1:0] i_rm,
  output logic [XLEN-1:0]       o_rdata1,
  output logic [XLEN-1:0]       o_rdata2,
  output logic                  o_byp1,
  output logic                  o_byp2
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_ok;

  // Writes to XZR or to addresses beyond NREG are dropped.
  assign w_wr_ok = i_we && (i_rd != ZERO_ADDR) && addr_in_range(i_rd, NREG);

  // Storage array write port; reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_rd[IDX_W-1:0]] <= i_wdata;
    end
  end

  // Read port 1: zero register, then bypass, then storage.
  always_comb begin
    o_rdata1 = '0;
    o_byp1   = 1'b0;
    if (i_rn == ZERO_ADDR || !addr_in_range(i_rn, NREG)) begin
      o_rdata1 = '0;
    end else if (i_we && i_rd == i_rn) begin
      o_rdata1 = i_wdata;
      o_byp1   = 1'b1;
    end else begin
      o_rdata1 = r_regs[i_rn[IDX_W-1:0]];
    end
  end

  // Read port 2: zero register, then bypass, then storage.
  always_comb begin
    o_rdata2 = '0;
    o_byp2   = 1'b0;
    if (i_rm == ZERO_ADDR || !addr_in_range(i_rm, NREG)) begin
      o_rdata2 = '0;
    end else if (i_we && i_rd == i_rm) begin
      o_rdata2 = i_wdata;
      o_byp2   = 1'b1;
    end else begin
      o_rdata2 = r_regs[i_rm[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/decode_regfile.sv
// Register file plus ID/EX operand latch with flush-over-stall control.
module decode_regfile
  import pipeline_pkg::*;
#(
  parameter int unsigned NREG     = pipeline_pkg::NREG,
  parameter int unsigned XLEN     = pipeline_pkg::XLEN,
  parameter int unsigned ZERO_REG = pipeline_pkg::ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite_ID,
  input  logic [REG_ADDR_W-1:0] RD_ID,
  input  logic [XLEN-1:0]       MemtoRegOut_ID,
  input  logic [REG_ADDR_W-1:0] RN_ID,
  input  logic [REG_ADDR_W-1:0] RM_ID,
  input  logic                  Valid_ID,
  input  logic                  Stall_ID,
  input  logic                  Flush_ID,
  output logic [XLEN-1:0]       ReadData1_EX,
  output logic [XLEN-1:0]       ReadData2_EX,
  output logic                  Valid_EX,
  output logic                  Bypass1_EX,
  output logic                  Bypass2_EX
);

  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;
  logic            w_byp1;
  logic            w_byp2;
  idex_t           w_next;
  idex_t           r_idex;

  regfile_core #(
    .NREG     (NREG),
    .XLEN     (XLEN),
    .ZERO_REG (ZERO_REG)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .i_we     (RegWrite_ID),
    .i_rd     (RD_ID),
    .i_wdata  (MemtoRegOut_ID),
    .i_rn     (RN_ID),
    .i_rm     (RM_ID),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .o_byp1   (w_byp1),
    .o_byp2   (w_byp2)
  );

  // Bundle the current read-port results for the latch.
  always_comb begin
    w_next       = '0;
    w_next.valid = Valid_ID;
    w_next.rd1   = w_rdata1;
    w_next.rd2   = w_rdata2;
    w_next.byp1  = w_byp1;
    w_next.byp2  = w_byp2;
  end

  // ID/EX latch: flush clears, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex <= '0;
    end else if (Flush_ID) begin
      r_idex <= '0;
    end else if (!Stall_ID) begin
      r_idex <= w_next;
    end
  end

  assign ReadData1_EX = r_idex.rd1;
  assign ReadData2_EX = r_idex.rd2;
  assign Valid_EX     = r_idex.valid;
  assign Bypass1_EX   = r_idex.byp1;
  assign Bypass2_EX   = r_idex.byp2;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed, table-driven bench for decode_regfile.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_ID;
  logic [4:0]  RD_ID;
  logic [63:0] MemtoRegOut_ID;
  logic [4:0]  RN_ID;
  logic [4:0]  RM_ID;
  logic        Valid_ID;
  logic        Stall_ID;
  logic        Flush_ID;
  logic [63:0] ReadData1_EX;
  logic [63:0] ReadData2_EX;
  logic        Valid_EX;
  logic        Bypass1_EX;
  logic        Bypass2_EX;

  int tests  = 0;
  int failed = 0;

  decode_regfile #(
    .NREG     (32),
    .XLEN     (64),
    .ZERO_REG (31)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .RegWrite_ID    (RegWrite_ID),
    .RD_ID          (RD_ID),
    .MemtoRegOut_ID (MemtoRegOut_ID),
    .RN_ID          (RN_ID),
    .RM_ID          (RM_ID),
    .Valid_ID       (Valid_ID),
    .Stall_ID       (Stall_ID),
    .Flush_ID       (Flush_ID),
    .ReadData1_EX   (ReadData1_EX),
    .ReadData2_EX   (ReadData2_EX),
    .Valid_EX       (Valid_EX),
    .Bypass1_EX     (Bypass1_EX),
    .Bypass2_EX     (Bypass2_EX)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [63:0] e_rd1;
    logic [63:0] e_rd2;
    logic        e_valid;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [63:0] r1, input logic [63:0] r2,
                         input logic v, input logic b1, input logic b2);
    chk({name, ".rd1"}, ReadData1_EX, r1);
    chk({name, ".rd2"}, ReadData2_EX, r2);
    chk({name, ".valid"}, 64'(Valid_EX), 64'(v));
    chk({name, ".byp1"}, 64'(Bypass1_EX), 64'(b1));
    chk({name, ".byp2"}, 64'(Bypass2_EX), 64'(b2));
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] wd,
                       input logic [4:0] rn, input logic [4:0] rm, input logic v,
                       input logic st, input logic fl);
    RegWrite_ID = we; RD_ID = rd; MemtoRegOut_ID = wd;
    RN_ID = rn; RM_ID = rm; Valid_ID = v; Stall_ID = st; Flush_ID = fl;
  endtask

  task automatic add(input string n, input logic we, input logic [4:0] rd, input logic [63:0] wd,
                     input logic [4:0] rn, input logic [4:0] rm, input logic v, input logic st,
                     input logic fl, input logic [63:0] r1, input logic [63:0] r2,
                     input logic ev, input logic b1, input logic b2);
    vec_t x;
    x.name = n; x.we = we; x.rd = rd; x.wdata = wd; x.rn = rn; x.rm = rm;
    x.valid = v; x.stall = st; x.flush = fl;
    x.e_rd1 = r1; x.e_rd2 = r2; x.e_valid = ev; x.e_b1 = b1; x.e_b2 = b2;
    vecs.push_back(x);
  endtask

  initial begin
    // Each row is one cycle; expectations are EX outputs after that edge.
    //    name        we rd  wdata               rn rm v st fl  rd1                  rd2                  V b1 b2
    add("rst_read",   0, 0,  64'h0,              3, 31,1, 0, 0, 64'h0,               64'h0,               1, 0, 0);
    add("wr_x5",      1, 5,  64'hDEAD_BEEF,      3, 31,1, 0, 0, 64'h0,               64'h0,               1, 0, 0);
    add("rd_x5",      0, 0,  64'h0,              5, 5, 1, 0, 0, 64'hDEAD_BEEF,       64'hDEAD_BEEF,       1, 0, 0);
    add("byp_x7",     1, 7,  64'h1234,           7, 7, 1, 0, 0, 64'h1234,            64'h1234,            1, 1, 1);
    add("rd_x7",      0, 0,  64'h0,              7, 5, 1, 0, 0, 64'h1234,            64'hDEAD_BEEF,       1, 0, 0);
    add("wr_xzr",     1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 5, 1, 0, 0, 64'h0,         64'hDEAD_BEEF,       1, 0, 0);
    add("rd_xzr",     0, 0,  64'h0,              31,31,1, 0, 0, 64'h0,               64'h0,               1, 0, 0);
    add("latch_x2",   1, 2,  64'hAA,             2, 3, 0, 0, 0, 64'hAA,              64'h0,               0, 1, 0);
    add("stall1",     1, 2,  64'hBB,             2, 2, 1, 1, 0, 64'hAA,              64'h0,               0, 1, 0);
    add("stall2",     1, 2,  64'hBB,             2, 2, 1, 1, 0, 64'hAA,              64'h0,               0, 1, 0);
    add("stall3",     1, 2,  64'hBB,             2, 2, 1, 1, 0, 64'hAA,              64'h0,               0, 1, 0);
    add("release",    0, 0,  64'h0,              2, 2, 1, 0, 0, 64'hBB,              64'hBB,              1, 0, 0);
    add("stall_flush",0, 0,  64'h0,              5, 7, 1, 1, 1, 64'h0,               64'h0,               0, 0, 0);
    add("wr_x9",      1, 9,  64'h55,             5, 2, 1, 0, 0, 64'hDEAD_BEEF,       64'hBB,              1, 0, 0);
    add("rd_x9",      0, 0,  64'h0,              9, 9, 1, 0, 0, 64'h55,              64'h55,              1, 0, 0);
    add("byp_one",    1, 3,  64'h77,             3, 9, 1, 0, 0, 64'h77,              64'h55,              1, 1, 0);
    add("flush_only", 0, 0,  64'h0,              9, 3, 1, 0, 1, 64'h0,               64'h0,               0, 0, 0);
    add("rd_x3",      0, 0,  64'h0,              3, 7, 1, 0, 0, 64'h77,              64'h1234,            1, 0, 0);

    drive(0, 0, 64'h0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].rd, vecs[i].wdata, vecs[i].rn, vecs[i].rm,
            vecs[i].valid, vecs[i].stall, vecs[i].flush);
      @(posedge clk);
      #1;
      chk_all(vecs[i].name, vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_valid,
              vecs[i].e_b1, vecs[i].e_b2);
    end

    // Async reset between edges clears outputs with no clock edge.
    drive(0, 0, 64'h0, 9, 9, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_all("pre_areset", 64'h55, 64'h55, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("areset_now", 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    // A write presented while reset spans an edge must be discarded.
    drive(1, 4, 64'h99, 9, 4, 1, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 64'h0, 9, 4, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_areset", 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // First write after reset release is accepted.
    drive(1, 4, 64'h99, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 64'h0, 4, 9, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_all("wr_after_rst", 64'h99, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
